// File: rtl/switch_pkg.sv
// Shared constants and types for the slide-switch conditioning path.
package switch_pkg;

  localparam int NSW_DEFAULT = 10;

  // Power-on switch setting expected by the cpu (bit 4 set).
  localparam logic [NSW_DEFAULT-1:0] SW_RESET_DEFAULT = 10'b0000010000;

  // Switch roles as seen by the cpu.
  localparam int SW_LOAD_IDX      = 8;
  localparam int SW_CLOCK_SEL_IDX = 9;

  typedef logic [NSW_DEFAULT-1:0] sw_vec_t;

endpackage

// File: rtl/switch_debounce_bit.sv
// debounce_bit: one switch's 2-flop synchroniser, consecutive-mismatch
// counter, accepted level flop and edge pulse flops.
// Optional: SW_RELEASE_PULSE_EN adds the `released` 1->0 pulse output.
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VALUE     = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic pressed,
`ifdef SW_RELEASE_PULSE_EN
  output logic released,
`endif
  output logic busy_next
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // Counter tops out one below the threshold; the accepting edge clears it,
  // so the counter can never wrap.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;

  // Count consecutive cycles where the synchronised level differs from the
  // accepted one; any agreement restarts the count.
  always_comb begin
    cnt_next = '0;
    accept   = 1'b0;
    if (sync2 != level) begin
      if (cnt == CNT_LAST) begin
        accept = 1'b1;
      end else begin
        cnt_next = cnt + 1'b1;
      end
    end
  end

  // Next-state busy is exported so the top can register the OR with the
  // same timing as the counters themselves.
  assign busy_next = (cnt_next != '0);

  // Synchroniser, counter, accepted level and one-cycle edge pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= RESET_VALUE;
      sync2    <= RESET_VALUE;
      cnt      <= '0;
      level    <= RESET_VALUE;
      pressed  <= 1'b0;
`ifdef SW_RELEASE_PULSE_EN
      released <= 1'b0;
`endif
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      cnt      <= cnt_next;
      if (accept) begin
        level <= sync2;
      end
      pressed  <= accept & sync2;
`ifdef SW_RELEASE_PULSE_EN
      released <= accept & ~sync2;
`endif
    end
  end

endmodule

// File: rtl/switch_debounce.sv
// switch_debounce: conditions the raw slide switches feeding the cpu
// Switches input. One debounce_bit per switch plus a registered busy flag.
// Optional: SW_RELEASE_PULSE_EN adds the SwReleased output.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int             NSW             = NSW_DEFAULT,
  parameter int             DEBOUNCE_CYCLES = 4,
  parameter logic [NSW-1:0] RESET_VALUE     = NSW'(SW_RESET_DEFAULT)
) (
  input  logic           Clock,
  input  logic           nReset,
  input  logic [NSW-1:0] SwRaw,
  output logic [NSW-1:0] Switches,
  output logic [NSW-1:0] SwPressed,
`ifdef SW_RELEASE_PULSE_EN
  output logic [NSW-1:0] SwReleased,
`endif
  output logic           Busy
);

  logic [NSW-1:0] busy_next;

  for (genvar i = 0; i < NSW; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RESET_VALUE[i])
    ) u_bit (
      .clk       (Clock),
      .rst_n     (nReset),
      .raw       (SwRaw[i]),
      .level     (Switches[i]),
      .pressed   (SwPressed[i]),
`ifdef SW_RELEASE_PULSE_EN
      .released  (SwReleased[i]),
`endif
      .busy_next (busy_next[i])
    );
  end

  // Busy is high whenever any bit is part-way through a count.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      Busy <= 1'b0;
    end else begin
      Busy <= |busy_next;
    end
  end

endmodule
